// File: rtl/dac_pkg.sv
// Shared definitions for the LTC2624 SPI master.
// Frame layout, command/address codes and FSM state encoding.
package dac_pkg;

  typedef enum logic [2:0] {
    S_CLR,
    S_IDLE,
    S_SETUP,
    S_SCK_HI,
    S_SCK_LO,
    S_GAP
  } state_t;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;

  localparam logic [3:0] ADDR_A   = 4'h0;
  localparam logic [3:0] ADDR_B   = 4'h1;
  localparam logic [3:0] ADDR_C   = 4'h2;
  localparam logic [3:0] ADDR_D   = 4'h3;
  localparam logic [3:0] ADDR_ALL = 4'hF;

  localparam int FRAME_LEN = 32;
  localparam int DATA_LSB  = 4;
  localparam int DATA_MSB  = 15;
  localparam int ADDR_LSB  = 16;
  localparam int ADDR_MSB  = 19;
  localparam int CMD_LSB   = 20;
  localparam int CMD_MSB   = 23;

  function automatic logic [FRAME_LEN-1:0] build_frame(
    input logic [3:0]  c,
    input logic [3:0]  a,
    input logic [11:0] d
  );
    logic [FRAME_LEN-1:0] f;
    f = '0;
    f[DATA_MSB:DATA_LSB] = d;
    f[ADDR_MSB:ADDR_LSB] = a;
    f[CMD_MSB:CMD_LSB]   = c;
    return f;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter with a one-cycle expiry tick.
// Tick fires on the last cycle of a loaded interval of N cycles.
module spi_phase_timer #(
  parameter int             W       = 6,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt;

  // Count down to zero; a load restarts the interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == W'(1));

endmodule

// File: rtl/dac_spi_ctrl.sv
// SPI master for the LTC2624 quad DAC: clear pulse after reset,
// then one 32-bit frame per accepted start, with readback capture.
module dac_spi_ctrl
  import dac_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int CLR_CYCLES = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  cmd,
  input  logic [3:0]  addr,
  input  logic [11:0] data,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        SPI_SCK,
  output logic        DAC_CS,
  output logic        DAC_CLR,
  output logic        SPI_MOSI,
  input  logic        DAC_OUT
);

  localparam int MAXC = (CLK_DIV > CLR_CYCLES) ? CLK_DIV : CLR_CYCLES;
  localparam int W    = $clog2(MAXC + 1);
  localparam logic [W-1:0] DIV  = W'(CLK_DIV);
  localparam logic [W-1:0] CLRV = W'(CLR_CYCLES);

  state_t      state;
  logic [31:0] tx;
  logic [4:0]  bit_cnt;
  logic        tick;
  logic        load;
  logic        accept;

  // A start landing on the done cycle is treated as still busy.
  assign accept = (state == S_IDLE) && start && !done;

  // Reload the phase timer on every transition into a timed phase.
  always_comb begin
    load = accept;
    if (tick && (state == S_SETUP || state == S_SCK_HI ||
                 state == S_SCK_LO))
      load = 1'b1;
  end

  spi_phase_timer #(
    .W       (W),
    .RST_VAL (CLRV)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (DIV),
    .tick     (tick)
  );

  // Frame sequencer; all pin outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_CLR;
      SPI_SCK  <= 1'b0;
      DAC_CS   <= 1'b1;
      DAC_CLR  <= 1'b0;
      SPI_MOSI <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
      rdata    <= '0;
      tx       <= '0;
      bit_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_CLR: begin
          if (DAC_CLR) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            DAC_CLR <= 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            tx       <= build_frame(cmd, addr, data);
            SPI_MOSI <= build_frame(cmd, addr, data)[31];
            DAC_CS   <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tick) begin
            SPI_SCK <= 1'b1;
            rdata   <= {rdata[30:0], DAC_OUT};
            state   <= S_SCK_HI;
          end
        end
        S_SCK_HI: begin
          if (tick) begin
            SPI_SCK  <= 1'b0;
            tx       <= {tx[30:0], 1'b0};
            SPI_MOSI <= tx[30];
            state    <= S_SCK_LO;
          end
        end
        S_SCK_LO: begin
          if (tick) begin
            if (bit_cnt == 5'd31) begin
              DAC_CS   <= 1'b1;
              SPI_MOSI <= 1'b0;
              state    <= S_GAP;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              SPI_SCK <= 1'b1;
              rdata   <= {rdata[30:0], DAC_OUT};
              state   <= S_SCK_HI;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_CLR;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// Bench for dac_spi_ctrl with a behavioural LTC2624 model.
// Scoreboard of expected frames checked on each done pulse.
module tb_dac_spi_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, busy, done;
  logic [3:0]  cmd, addr;
  logic [11:0] data;
  logic [31:0] rdata;
  logic        sck, cs_n, clr_n, mosi, dac_out;

  logic        rst1, start1, busy1, done1;
  logic [31:0] rdata1;
  logic        sck1, cs1, clr1, mosi1;
  logic        dac_out1;

  dac_spi_ctrl #(.CLK_DIV(2), .CLR_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr),
    .data(data), .busy(busy), .done(done), .rdata(rdata),
    .SPI_SCK(sck), .DAC_CS(cs_n), .DAC_CLR(clr_n),
    .SPI_MOSI(mosi), .DAC_OUT(dac_out)
  );

  dac_spi_ctrl #(.CLK_DIV(1), .CLR_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .cmd(4'h3), .addr(4'h1),
    .data(12'h123), .busy(busy1), .done(done1), .rdata(rdata1),
    .SPI_SCK(sck1), .DAC_CS(cs1), .DAC_CLR(clr1),
    .SPI_MOSI(mosi1), .DAC_OUT(dac_out1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ndone = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // DAC model: shifts in MOSI on SCK rise, plays back previous word.
  logic [31:0] dac_prev = '0;
  logic [31:0] mosi_word = '0;
  logic [31:0] frame_word = '0;
  int nrise = 0;
  int frame_rises = 0;
  longint t_cs_rise = -1000;

  assign dac_out = (nrise < 32) ? dac_prev[5'(31 - nrise)] : 1'b0;

  always @(negedge cs_n or posedge sck) begin
    if (sck) begin
      mosi_word <= {mosi_word[30:0], mosi};
      nrise <= nrise + 1;
    end else begin
      nrise <= 0;
    end
  end

  always @(posedge cs_n or negedge clr_n) begin
    if (!clr_n) dac_prev <= '0;
    else if (nrise == 32) dac_prev <= mosi_word;
  end

  always @(posedge cs_n) begin
    frame_rises <= nrise;
    frame_word <= mosi_word;
    t_cs_rise <= $time;
  end

  always @(negedge cs_n) begin
    chk("cs_high_gap", 32'(($time - t_cs_rise) >= 30), 1);
  end

  // Pin-level rules: MOSI steady while SCK high, no SCK outside CS.
  int viol = 0, viol1 = 0;
  logic lm = 1'b0, lm1 = 1'b0;
  always @(negedge clk) begin
    if (sck && mosi !== lm) viol <= viol + 1;
    if (cs_n && sck) viol <= viol + 1;
    if (sck1 && mosi1 !== lm1) viol1 <= viol1 + 1;
    if (cs1 && sck1) viol1 <= viol1 + 1;
    lm <= mosi;
    lm1 <= mosi1;
  end

  logic [31:0] word1 = '0;
  int rises1 = 0;
  always @(posedge sck1) begin
    word1 <= {word1[30:0], mosi1};
    rises1 <= rises1 + 1;
  end

  typedef struct {
    logic [31:0] word;
    logic [31:0] rd;
    int c0;
  } exp_t;
  exp_t q[$];
  exp_t e;

  // Monitor: every done pops one expected frame.
  always @(negedge clk) begin
    if (!rst && done) begin
      ndone <= ndone + 1;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none",
                 cyc);
      end else begin
        e = q.pop_front();
        chk("frame_word", frame_word, e.word);
        chk("rdata", rdata, e.rd);
        chk("latency", 32'(cyc - e.c0), 133);
        chk("sck_rises", 32'(frame_rises), 32);
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [3:0] a,
                      input logic [11:0] d, input logic [31:0] w,
                      input logic [31:0] r, input bit push);
    cmd = c;
    addr = a;
    data = d;
    start = 1'b1;
    if (push) q.push_back('{w, r, cyc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic clear_seq();
    int n = 0;
    while (!clr_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("clr_low_cycles", n, 50);
    chk("busy_at_clr_rise", busy, 1);
    @(negedge clk);
    chk("busy_after_clr", busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int c0;
    rst = 1'b1;
    rst1 = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    dac_out1 = 1'b0;
    cmd = '0;
    addr = '0;
    data = '0;
    repeat (3) @(negedge clk);
    chk("reset_pins", {sck, cs_n, clr_n, mosi, busy, done}, 6'b010010);
    chk("reset_rdata", rdata, 0);
    rst = 1'b0;
    rst1 = 1'b0;
    clear_seq();

    send(4'h3, 4'h0, 12'hABC, 32'h0030ABC0, 32'h0, 1);
    wait_done();
    @(negedge clk);
    send(4'h3, 4'h1, 12'h123, 32'h00311230, 32'h0030ABC0, 1);
    wait_done();
    @(negedge clk);
    send(4'h3, 4'hF, 12'hFFF, 32'h003FFFF0, 32'h00311230, 1);
    wait_done();
    repeat (5) @(negedge clk);

    send(4'h3, 4'h2, 12'h555, 32'h00325550, 32'h003FFFF0, 1);
    repeat (40) @(negedge clk);
    data = 12'h111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    data = 12'h222;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_on_done_ignored", {busy, cs_n}, 2'b01);
    repeat (150) @(negedge clk);
    chk("done_count_busy", 32'(ndone), 4);

    send(4'h3, 4'h3, 12'h3A5, 32'h0, 32'h0, 0);
    n = 0;
    while (nrise < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_rise10", 32'(nrise), 10);
    rst = 1'b1;
    #1;
    chk("abort_pins", {sck, cs_n, clr_n, busy, done}, 5'b01010);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_seq();
    send(4'h3, 4'h3, 12'h3A5, 32'h00333A50, 32'h0, 1);
    wait_done();
    repeat (5) @(negedge clk);
    chk("done_count_total", 32'(ndone), 5);

    chk("d1_idle", busy1, 0);
    start1 = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("d1_latency", 32'(cyc - c0), 67);
    chk("d1_word", word1, 32'h00311230);
    chk("d1_rises", 32'(rises1), 32);
    chk("d1_rdata", rdata1, 0);

    repeat (5) @(negedge clk);
    chk("pin_rules", 32'(viol), 0);
    chk("pin_rules_d1", 32'(viol1), 0);
    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
